// File: rtl/mprj_wb_guard.sv
// Wishbone bus guard between the management core's user bus and the user project.
// Every master request is re-registered toward the user side. If the user project
// never acknowledges, the guard completes the cycle itself with ERR_DATA and logs
// the event in a sticky flag and a saturating counter.
module mprj_wb_guard #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        core_clk,
  input  logic        core_rstn,
  // Master side
  input  logic        m_cyc_i,
  input  logic        m_stb_i,
  input  logic        m_we_i,
  input  logic [3:0]  m_sel_i,
  input  logic [31:0] m_adr_i,
  input  logic [31:0] m_dat_i,
  output logic        m_ack_o,
  output logic [31:0] m_dat_o,
  // User project side
  output logic        u_cyc_o,
  output logic        u_stb_o,
  output logic        u_we_o,
  output logic [3:0]  u_sel_o,
  output logic [31:0] u_adr_o,
  output logic [31:0] u_dat_o,
  input  logic        u_ack_i,
  input  logic [31:0] u_dat_i,
  // Control and status
  input  logic        wb_iena,
  input  logic        to_clr,
  output logic        to_flag,
  output logic [7:0]  to_cnt,
  output logic        busy
);

  // Wide enough to hold TIMEOUT_CYCLES; the counter stops at TIMEOUT_CYCLES-1.
  localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             m_ack_q, m_ack_d;
  logic [31:0]      m_dat_q, m_dat_d;
  logic             u_cyc_q, u_cyc_d;
  logic             u_stb_q, u_stb_d;
  logic             u_we_q, u_we_d;
  logic [3:0]       u_sel_q, u_sel_d;
  logic [31:0]      u_adr_q, u_adr_d;
  logic [31:0]      u_dat_q, u_dat_d;
  logic             to_flag_q, to_flag_d;
  logic [7:0]       to_cnt_q, to_cnt_d;

  // Next-state logic: transfer FSM, timeout counter and timeout status.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_ack_d   = 1'b0;
    m_dat_d   = m_dat_q;
    u_cyc_d   = u_cyc_q;
    u_stb_d   = u_stb_q;
    u_we_d    = u_we_q;
    u_sel_d   = u_sel_q;
    u_adr_d   = u_adr_q;
    u_dat_d   = u_dat_q;
    to_flag_d = to_flag_q;
    to_cnt_d  = to_cnt_q;

    // Clear is applied first so a same-cycle timeout lands on a zeroed status.
    if (to_clr) begin
      to_flag_d = 1'b0;
      to_cnt_d  = 8'd0;
    end

    unique case (state_q)
      StIdle: begin
        if (m_cyc_i && m_stb_i) begin
          u_cyc_d = 1'b1;
          u_stb_d = 1'b1;
          u_we_d  = m_we_i;
          u_sel_d = m_sel_i;
          u_adr_d = m_adr_i;
          u_dat_d = m_dat_i;
          cnt_d   = '0;
          state_d = StReq;
        end
      end

      StReq: begin
        if (!m_cyc_i) begin
          // Master abandoned the cycle: withdraw silently, not a timeout.
          u_cyc_d = 1'b0;
          u_stb_d = 1'b0;
          state_d = StIdle;
        end else if (u_ack_i && wb_iena) begin
          // A qualified ack beats a coincident timeout.
          u_cyc_d = 1'b0;
          u_stb_d = 1'b0;
          m_dat_d = u_dat_i;
          m_ack_d = 1'b1;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          u_cyc_d   = 1'b0;
          u_stb_d   = 1'b0;
          m_dat_d   = ERR_DATA;
          m_ack_d   = 1'b1;
          to_flag_d = 1'b1;
          if (to_cnt_d != 8'hFF) begin
            to_cnt_d = to_cnt_d + 8'd1;
          end
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        u_cyc_d = 1'b0;
        u_stb_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything, including the buses.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      m_ack_q   <= 1'b0;
      m_dat_q   <= 32'd0;
      u_cyc_q   <= 1'b0;
      u_stb_q   <= 1'b0;
      u_we_q    <= 1'b0;
      u_sel_q   <= 4'd0;
      u_adr_q   <= 32'd0;
      u_dat_q   <= 32'd0;
      to_flag_q <= 1'b0;
      to_cnt_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_ack_q   <= m_ack_d;
      m_dat_q   <= m_dat_d;
      u_cyc_q   <= u_cyc_d;
      u_stb_q   <= u_stb_d;
      u_we_q    <= u_we_d;
      u_sel_q   <= u_sel_d;
      u_adr_q   <= u_adr_d;
      u_dat_q   <= u_dat_d;
      to_flag_q <= to_flag_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // All outputs come straight from registers.
  always_comb begin
    m_ack_o = m_ack_q;
    m_dat_o = m_dat_q;
    u_cyc_o = u_cyc_q;
    u_stb_o = u_stb_q;
    u_we_o  = u_we_q;
    u_sel_o = u_sel_q;
    u_adr_o = u_adr_q;
    u_dat_o = u_dat_q;
    to_flag = to_flag_q;
    to_cnt  = to_cnt_q;
    busy    = (state_q == StReq) || (state_q == StResp);
  end

endmodule

// File: tb/tb_mprj_wb_guard.sv
// Directed bench for mprj_wb_guard with an 8-cycle timeout.
module tb_mprj_wb_guard;

  logic        core_clk = 1'b0;
  logic        core_rstn;
  logic        m_cyc_i, m_stb_i, m_we_i;
  logic [3:0]  m_sel_i;
  logic [31:0] m_adr_i, m_dat_i;
  logic        m_ack_o;
  logic [31:0] m_dat_o;
  logic        u_cyc_o, u_stb_o, u_we_o;
  logic [3:0]  u_sel_o;
  logic [31:0] u_adr_o, u_dat_o;
  logic        u_ack_i;
  logic [31:0] u_dat_i;
  logic        wb_iena, to_clr;
  logic        to_flag;
  logic [7:0]  to_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mprj_wb_guard #(
    .TIMEOUT_CYCLES(8),
    .ERR_DATA      (32'hDEAD_BEEF)
  ) dut (
    .core_clk (core_clk),
    .core_rstn(core_rstn),
    .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),
    .m_we_i   (m_we_i),
    .m_sel_i  (m_sel_i),
    .m_adr_i  (m_adr_i),
    .m_dat_i  (m_dat_i),
    .m_ack_o  (m_ack_o),
    .m_dat_o  (m_dat_o),
    .u_cyc_o  (u_cyc_o),
    .u_stb_o  (u_stb_o),
    .u_we_o   (u_we_o),
    .u_sel_o  (u_sel_o),
    .u_adr_o  (u_adr_o),
    .u_dat_o  (u_dat_o),
    .u_ack_i  (u_ack_i),
    .u_dat_i  (u_dat_i),
    .wb_iena  (wb_iena),
    .to_clr   (to_clr),
    .to_flag  (to_flag),
    .to_cnt   (to_cnt),
    .busy     (busy)
  );

  always #5 core_clk = ~core_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  task automatic start_req(input logic we, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] dat);
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
    m_we_i  = we;
    m_sel_i = sel;
    m_adr_i = adr;
    m_dat_i = dat;
  endtask

  task automatic end_req();
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
  endtask

  // Full timed-out read; to_clr is held during the edge that fires the timeout.
  task automatic run_timeout(input logic clr_last);
    start_req(1'b0, 4'hF, 32'h3000_0100, 32'd0);
    step();            // request sampled, REQ with counter 0
    repeat (7) step(); // counter reaches 7
    to_clr = clr_last;
    step();            // timeout edge
    to_clr = 1'b0;
    end_req();
    step();            // back to IDLE
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    core_rstn = 1'b0;
    end_req();
    m_we_i = 1'b0; m_sel_i = 4'h0; m_adr_i = 32'd0; m_dat_i = 32'd0;
    u_ack_i = 1'b0; u_dat_i = 32'd0; wb_iena = 1'b1; to_clr = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_m_ack", {31'd0, m_ack_o}, 32'd0);
    check("rst_m_dat", m_dat_o, 32'd0);
    check("rst_u_stb", {30'd0, u_cyc_o, u_stb_o}, 32'd0);
    check("rst_u_adr", u_adr_o, 32'd0);
    check("rst_to", {23'd0, to_flag, to_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    core_rstn = 1'b1;
    step();

    // Read with the user ack three cycles after u_stb_o rises
    start_req(1'b0, 4'hF, 32'h3000_0004, 32'd0);
    step();
    check("rd_u_stb", {30'd0, u_cyc_o, u_stb_o}, 32'd3);
    check("rd_u_adr", u_adr_o, 32'h3000_0004);
    check("rd_busy", {31'd0, busy}, 32'd1);
    step();
    step();
    check("rd_wait_ack", {31'd0, m_ack_o}, 32'd0);
    u_ack_i = 1'b1; u_dat_i = 32'h1234_5678;
    step();
    u_ack_i = 1'b0; u_dat_i = 32'h0;
    end_req();
    check("rd_m_ack", {31'd0, m_ack_o}, 32'd1);
    check("rd_m_dat", m_dat_o, 32'h1234_5678);
    check("rd_u_drop", {30'd0, u_cyc_o, u_stb_o}, 32'd0);
    step();
    check("rd_ack_pulse", {31'd0, m_ack_o}, 32'd0);
    check("rd_idle", {31'd0, busy}, 32'd0);
    check("rd_to_flag", {31'd0, to_flag}, 32'd0);

    // Write mirrored to the user bus one cycle after sampling
    start_req(1'b1, 4'b0011, 32'h3000_0010, 32'hA5A5_A5A5);
    step();
    check("wr_u_we", {31'd0, u_we_o}, 32'd1);
    check("wr_u_sel", {28'd0, u_sel_o}, 32'h3);
    check("wr_u_adr", u_adr_o, 32'h3000_0010);
    check("wr_u_dat", u_dat_o, 32'hA5A5_A5A5);
    u_ack_i = 1'b1;
    step();
    u_ack_i = 1'b0;
    end_req();
    check("wr_m_ack", {31'd0, m_ack_o}, 32'd1);
    step();
    check("wr_ack_pulse", {31'd0, m_ack_o}, 32'd0);

    // Timeout while u_ack_i is held high but not enabled
    wb_iena = 1'b0; u_ack_i = 1'b1; u_dat_i = 32'h1111_1111;
    start_req(1'b0, 4'hF, 32'h3000_0020, 32'd0);
    step();
    repeat (7) step();
    check("to_stb_8th", {31'd0, u_stb_o}, 32'd1);
    check("to_no_ack_yet", {31'd0, m_ack_o}, 32'd0);
    step();
    end_req();
    check("to_stb_drop", {31'd0, u_stb_o}, 32'd0);
    check("to_m_ack", {31'd0, m_ack_o}, 32'd1);
    check("to_m_dat", m_dat_o, 32'hDEAD_BEEF);
    check("to_flag", {31'd0, to_flag}, 32'd1);
    check("to_cnt1", {24'd0, to_cnt}, 32'd1);
    u_ack_i = 1'b0; wb_iena = 1'b1;
    step();
    check("to_ack_pulse", {31'd0, m_ack_o}, 32'd0);

    // Qualified ack on the exact timeout edge wins
    start_req(1'b0, 4'hF, 32'h3000_0030, 32'd0);
    step();
    repeat (7) step();
    u_ack_i = 1'b1; u_dat_i = 32'hCAFE_F00D;
    step();
    u_ack_i = 1'b0;
    end_req();
    check("race_m_ack", {31'd0, m_ack_o}, 32'd1);
    check("race_m_dat", m_dat_o, 32'hCAFE_F00D);
    check("race_to_cnt", {24'd0, to_cnt}, 32'd1);
    step();

    // Master drops m_cyc_i in the second REQ cycle
    start_req(1'b0, 4'hF, 32'h3000_0040, 32'd0);
    step();
    step();
    end_req();
    step();
    check("abort_u_drop", {30'd0, u_cyc_o, u_stb_o}, 32'd0);
    check("abort_no_ack", {31'd0, m_ack_o}, 32'd0);
    check("abort_idle", {31'd0, busy}, 32'd0);
    step();
    check("abort_no_ack2", {31'd0, m_ack_o}, 32'd0);
    check("abort_to_cnt", {24'd0, to_cnt}, 32'd1);

    // Counter increments, then clear coincident with a timeout
    run_timeout(1'b0);
    check("to_cnt2", {24'd0, to_cnt}, 32'd2);
    run_timeout(1'b1);
    check("clr_to_flag", {31'd0, to_flag}, 32'd1);
    check("clr_to_cnt", {24'd0, to_cnt}, 32'd1);
    to_clr = 1'b1;
    step();
    to_clr = 1'b0;
    check("clr_only", {23'd0, to_flag, to_cnt}, 32'd0);

    // Saturation
    for (int i = 0; i < 300; i++) run_timeout(1'b0);
    check("sat_to_cnt", {24'd0, to_cnt}, 32'd255);
    check("sat_to_flag", {31'd0, to_flag}, 32'd1);

    // Asynchronous reset mid-REQ, then a normal transfer
    start_req(1'b0, 4'hF, 32'h3000_0050, 32'd0);
    step();
    step();
    #2;
    core_rstn = 1'b0;
    #1;
    check("arst_u_stb", {30'd0, u_cyc_o, u_stb_o}, 32'd0);
    check("arst_u_adr", u_adr_o, 32'd0);
    check("arst_m_dat", m_dat_o, 32'd0);
    check("arst_to", {23'd0, to_flag, to_cnt}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    #1;
    core_rstn = 1'b1;
    step();
    check("post_rst_stb", {31'd0, u_stb_o}, 32'd1);
    check("post_rst_no_ack", {31'd0, m_ack_o}, 32'd0);
    u_ack_i = 1'b1; u_dat_i = 32'h0BAD_F00D;
    step();
    u_ack_i = 1'b0;
    end_req();
    check("post_rst_ack", {31'd0, m_ack_o}, 32'd1);
    check("post_rst_dat", m_dat_o, 32'h0BAD_F00D);
    step();
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mprj_wb_guard.md
MPRJ_WB_GUARD -- requirements
Module: mprj_wb_guard

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, sets the number of REQ-state cycles without a user ack before an abort; legal range is 1..65535.
REQ-002 Parameter ERR_DATA, default 32'hDEAD_BEEF, is the read data returned to the master on a timeout.
REQ-003 core_clk  in  1  single block clock, rising-edge.
REQ-004 core_rstn  in  1  reset, asynchronous assert, active-low.
REQ-005 m_cyc_i, m_stb_i, m_we_i  in  1 each  Wishbone request from the management core's exported user bus.
REQ-006 m_sel_i  in  4, m_adr_i  in  32, m_dat_i  in  32  master byte select, address and write data.
REQ-007 m_ack_o  out  1, m_dat_o  out  32  master acknowledge and read data.
REQ-008 u_cyc_o, u_stb_o, u_we_o  out  1 each, u_sel_o  out  4, u_adr_o  out  32, u_dat_o  out  32  request to the user project.
REQ-009 u_ack_i  in  1, u_dat_i  in  32  user project response.
REQ-010 wb_iena  in  1  user-response enable; when low, u_ack_i is ignored.
REQ-011 to_clr  in  1  clears the timeout status.
REQ-012 to_flag  out  1  sticky timeout flag, usable as an IRQ source.
REQ-013 to_cnt  out  8  saturating timeout count.
REQ-014 busy  out  1  high in REQ and RESP.

Function
REQ-015 The FSM SHALL have three states: IDLE, REQ and RESP.
REQ-016 IDLE: when m_cyc_i&m_stb_i=1 at a clock edge, latch we/sel/adr/dat into the u_* registers, set u_cyc_o=u_stb_o=1, clear the counter and go to REQ.
REQ-017 Request latency is exactly one cycle: sampled at edge N, u_stb_o is high after edge N.
REQ-018 REQ: when u_ack_i&wb_iena=1, capture u_dat_i into m_dat_o, drop u_cyc_o/u_stb_o, set m_ack_o=1 and go to RESP.
REQ-019 REQ, with no qualified ack: increment the counter each cycle; when the counter equals TIMEOUT_CYCLES-1, drop u_cyc_o/u_stb_o, load m_dat_o=ERR_DATA, set m_ack_o=1, set to_flag, increment to_cnt (saturating at 255) and go to RESP.
REQ-020 If a qualified ack and the timeout condition occur in the same cycle, the ack wins and no timeout is recorded.
REQ-021 If m_cyc_i drops while in REQ, drop u_cyc_o/u_stb_o the next cycle, assert no m_ack_o and return to IDLE; this abort is not counted as a timeout.
REQ-022 RESP lasts exactly one cycle with m_ack_o=1, then goes to IDLE with m_ack_o=0; a new request is accepted no earlier than the IDLE cycle.
REQ-023 u_ack_i is ignored in IDLE and RESP.
REQ-024 u_ack_i is ignored in any cycle where wb_iena=0; those cycles still count toward the timeout.
REQ-025 m_dat_o holds its last value outside RESP; only its value during m_ack_o=1 is defined.
REQ-026 The counter width is ceil(log2(TIMEOUT_CYCLES+1)) bits; the counter never wraps.
REQ-027 to_clr=1 clears to_flag and to_cnt at the next edge.
REQ-028 If to_clr and a timeout occur in the same cycle, the outcome is to_flag=1 and to_cnt=1.
REQ-029 busy=1 exactly when the state is REQ or RESP.

Reset
REQ-030 While core_rstn=0, state=IDLE and all outputs are 0, including m_dat_o and the u_* buses; to_cnt=0 and to_flag=0.
REQ-031 Reset assertion takes effect asynchronously; release is sampled on core_clk.
REQ-032 Reset in REQ drops u_cyc_o/u_stb_o immediately, and no m_ack_o is issued for the lost transfer.

Verification
REQ-033 Read adr=0x3000_0004; u_ack_i with u_dat_i=0x1234_5678 three cycles after u_stb_o -> m_ack_o high 1 cycle later with m_dat_o=0x1234_5678; to_flag stays 0.
REQ-034 Write sel=4'b0011, dat=0xA5A5_A5A5 -> u_* signals mirror the request one cycle after the request is sampled; ack -> m_ack_o pulse of one cycle.
REQ-035 TIMEOUT_CYCLES=8, no user ack -> u_stb_o drops after 8 REQ cycles, m_dat_o=0xDEAD_BEEF, to_flag=1, to_cnt=1; repeat 300 times -> to_cnt=255.
REQ-036 u_ack_i=1 with wb_iena=0 -> ignored, and a timeout occurs; u_ack_i in the exact timeout cycle with wb_iena=1 -> normal ack, to_cnt unchanged.
REQ-037 m_cyc_i dropped in the 2nd REQ cycle -> no m_ack_o, return to IDLE; to_clr together with a timeout -> to_flag=1, to_cnt=1.
REQ-038 core_rstn pulsed low mid-REQ -> all outputs are 0 immediately; the next request completes normally.
